// File: rtl/flag_branch_unit_if.sv
// flag_branch_unit_if: execute-stage flag results and branch handshake bundle.
// The master side drives ALU results and branch requests. The slave side is
// the flag/branch unit, which returns br_ready and the registered resolution.
interface flag_branch_unit_if;
  logic       ex_valid;
  logic [2:0] ex_opcode;
  logic [2:0] ex_flags;
  logic       br_valid;
  logic [2:0] br_ccc;
  logic       br_ready;
  logic       br_res_valid;
  logic       br_taken;

  modport master (
    output ex_valid, ex_opcode, ex_flags, br_valid, br_ccc,
    input  br_ready, br_res_valid, br_taken
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_flags, br_valid, br_ccc,
    output br_ready, br_res_valid, br_taken
  );
endinterface

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural {Z,V,N} flag register plus branch condition
// resolution.
// Optional feature macro FLAG_FWD_EN: when defined, branches never stall.
// They are evaluated against the flags as merged with this cycle's ALU write.
// Without it, a branch waits out every cycle that carries a flag-writing op.
// A saturating counter records those stall cycles.
module flag_branch_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  flag_branch_unit_if.slave      bus,
  output logic [2:0]             flags_q,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Condition code evaluation over flags {Z,V,N}.
  function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    logic r;
    z = f[2];
    v = f[1];
    n = f[0];
    case (ccc)
      3'b000:  r = ~z;                    // NE
      3'b001:  r = z;                     // EQ
      3'b010:  r = ~z & ~n;               // GT
      3'b011:  r = n;                     // LT
      3'b100:  r = z | (~z & ~n);         // GTE
      3'b101:  r = n | z;                 // LTE
      3'b110:  r = v;                     // OVF
      default: r = 1'b1;                  // always
    endcase
    return r;
  endfunction

  // Apply the ALU write mask over the current flags.
  // ADD/SUB write all three flags, XOR/RED write Z only, and 1xx writes nothing.
  function automatic logic [2:0] merge_flags(input logic       ev,
                                             input logic [2:0] op,
                                             input logic [2:0] fl,
                                             input logic [2:0] cur);
    logic [2:0] r;
    if (!ev) begin
      r = cur;
    end else begin
      case (op)
        3'b000, 3'b001: r = fl;
        3'b010, 3'b011: r = {fl[2], cur[1:0]};
        default:        r = cur;
      endcase
    end
    return r;
  endfunction

  logic       flag_write_s;
  logic [2:0] next_flags_s;
  logic [2:0] eval_flags_s;
  logic       accept_s;
  logic       stall_s;
  logic       stall_sat_s;

  // Hazard detection, handshake and the flag view used for evaluation.
  always_comb begin
    flag_write_s = bus.ex_valid & ~bus.ex_opcode[2];
    next_flags_s = merge_flags(bus.ex_valid, bus.ex_opcode, bus.ex_flags, flags_q);
`ifdef FLAG_FWD_EN
    bus.br_ready = 1'b1;
    eval_flags_s = next_flags_s;
`else
    bus.br_ready = ~flag_write_s;
    eval_flags_s = flags_q;
`endif
    accept_s    = bus.br_valid & bus.br_ready;
    stall_s     = bus.br_valid & ~bus.br_ready;
    stall_sat_s = &stall_cnt;
  end

  // Flag register, registered resolution pulse and saturating stall counter.
  // Reset wins over every same-cycle write or accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q          <= 3'b000;
      bus.br_taken     <= 1'b0;
      bus.br_res_valid <= 1'b0;
      stall_cnt        <= {STALL_CNT_W{1'b0}};
    end else begin
      flags_q          <= next_flags_s;
      bus.br_res_valid <= accept_s;
      if (accept_s) begin
        bus.br_taken <= cond_eval(bus.br_ccc, eval_flags_s);
      end else begin
        bus.br_taken <= bus.br_taken;
      end
      if (stall_s && !stall_sat_s) begin
        stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed vectors against flag_branch_unit.
// Expected resolutions are queued when a branch is issued. A separate monitor
// pops the queue and compares whenever the unit presents br_res_valid.
module tb_flag_branch_unit;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  flags_q;
  logic [15:0] stall_cnt;
  logic [2:0]  flags_q4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  flag_branch_unit_if bus ();
  flag_branch_unit_if bus4 ();

  flag_branch_unit #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flags_q(flags_q), .stall_cnt(stall_cnt)
  );

  flag_branch_unit #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .flags_q(flags_q4), .stall_cnt(stall_cnt4)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];
  logic acc_q    = 1'b0;
  int   exp_stall = 0;

  function automatic logic model_taken(input logic [2:0] c, input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    logic r;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0:    r = !z;
      3'd1:    r = z;
      3'd2:    r = !z && !n;
      3'd3:    r = n;
      3'd4:    r = z || (!z && !n);
      3'd5:    r = n || z;
      3'd6:    r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.ex_valid  = 1'b0;
    bus.ex_opcode = 3'b000;
    bus.ex_flags  = 3'b000;
    bus.br_valid  = 1'b0;
    bus.br_ccc    = 3'b000;
  endtask

  // One cycle of stimulus. The task starts just after a rising edge and
  // returns just after the next one. acc reports whether the branch was accepted.
  task automatic drive(input logic ev, input logic [2:0] op, input logic [2:0] fl,
                       input logic bv, input logic [2:0] ccc, output logic acc);
    bus.ex_valid  = ev;
    bus.ex_opcode = op;
    bus.ex_flags  = fl;
    bus.br_valid  = bv;
    bus.br_ccc    = ccc;
    #1;
    acc = bv && bus.br_ready;
    @(posedge clk);
    #1;
  endtask

  // Record which edges accepted a branch.
  initial forever begin
    @(posedge clk);
    acc_q = bus.br_valid && bus.br_ready && !rst;
  end

  // Monitor: a pulse must follow each accept by exactly one cycle.
  // Each pulse resolves the oldest queued expectation.
  initial forever begin
    logic e;
    @(negedge clk);
    if (acc_q || bus.br_res_valid) begin
      n_checks++;
      if (bus.br_res_valid !== acc_q) begin
        n_fail++;
        $display("FAIL pulse_timing: br_res_valid=%0b expected %0b", bus.br_res_valid, acc_q);
      end
    end
    if (bus.br_res_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: br_taken=%0b with no branch outstanding", bus.br_taken);
      end else begin
        e = exp_q.pop_front();
        if (bus.br_taken !== e) begin
          n_fail++;
          $display("FAIL br_taken: got %0b expected %0b", bus.br_taken, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       a;
    logic       acc;
    int         tries;
    logic [2:0] sub_seq [3];
    sub_seq[0] = 3'b100;
    sub_seq[1] = 3'b010;
    sub_seq[2] = 3'b001;

    rst = 1'b1;
    idle();
    bus4.ex_valid = 1'b0; bus4.ex_opcode = 3'b000; bus4.ex_flags = 3'b000;
    bus4.br_valid = 1'b0; bus4.br_ccc = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 32'(flags_q), 32'h0);
    check("reset_stall", 32'(stall_cnt), 32'h0);
    check("reset_res_valid", 32'(bus.br_res_valid), 32'h0);
    check("reset_taken", 32'(bus.br_taken), 32'h0);
    rst = 1'b0;

    // ADD Z=1 together with a BEQ branch.
    exp_q.push_back(1'b1);
    drive(1'b1, 3'b000, 3'b100, 1'b1, 3'b001, a);
    check("ready_during_add", 32'(a), 32'(FWD));
    check("flags_after_add", 32'(flags_q), 32'h4);
    tries = 0;
    while (!a && tries < 10) begin
      drive(1'b0, 3'b000, 3'b000, 1'b1, 3'b001, a);
      tries++;
    end
    check("accept_after_stall", 32'(a), 32'h1);
    idle();
    exp_stall += FWD ? 0 : 1;
    check("stall_one", 32'(stall_cnt), 32'(exp_stall));

    // Write masks: XOR and RED touch Z only, and 1xx ops write nothing.
    drive(1'b1, 3'b000, 3'b011, 1'b0, 3'b000, a);
    check("flags_add_011", 32'(flags_q), 32'h3);
    drive(1'b1, 3'b010, 3'b000, 1'b0, 3'b000, a);
    check("flags_xor_keep_vn", 32'(flags_q), 32'h3);
    drive(1'b1, 3'b011, 3'b100, 1'b0, 3'b000, a);
    check("flags_red_z", 32'(flags_q), 32'h7);
    drive(1'b1, 3'b100, 3'b000, 1'b0, 3'b000, a);
    check("flags_nonflag_op", 32'(flags_q), 32'h7);
    drive(1'b0, 3'b001, 3'b000, 1'b0, 3'b000, a);
    check("flags_hold_idle", 32'(flags_q), 32'h7);
    check("stall_no_branch", 32'(stall_cnt), 32'(exp_stall));

    // Every condition code against every flag value, issued back to back.
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 3'b000, 3'(f), 1'b0, 3'b000, a);
      check("sweep_flags", 32'(flags_q), 32'(f));
      for (int c = 0; c < 8; c++) begin
        exp_q.push_back(model_taken(3'(c), 3'(f)));
        drive(1'b0, 3'b000, 3'b000, 1'b1, 3'(c), a);
        check("sweep_accept", 32'(a), 32'h1);
      end
      idle();
    end

    // Three SUBs back to back while a BLT branch waits.
    exp_q.push_back(FWD ? 1'b0 : 1'b1);
    acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b001, sub_seq[k], !acc, 3'b011, a);
      acc = acc | a;
    end
    tries = 0;
    while (!acc && tries < 10) begin
      drive(1'b0, 3'b000, 3'b000, 1'b1, 3'b011, a);
      acc = acc | a;
      tries++;
    end
    check("accept_after_subs", 32'(acc), 32'h1);
    idle();
    exp_stall += FWD ? 0 : 3;
    check("stall_three", 32'(stall_cnt), 32'(exp_stall));
    check("flags_third_sub", 32'(flags_q), 32'h1);

    // Saturation on the 4-bit counter instance.
    bus4.ex_valid = 1'b1; bus4.ex_opcode = 3'b001; bus4.ex_flags = 3'b000;
    bus4.br_valid = 1'b1; bus4.br_ccc = 3'b111;
    repeat (15) @(posedge clk);
    #1;
    check("stall4_at_15", 32'(stall_cnt4), FWD ? 32'h0 : 32'hF);
    repeat (5) @(posedge clk);
    #1;
    check("stall4_saturated", 32'(stall_cnt4), FWD ? 32'h0 : 32'hF);
    bus4.ex_valid = 1'b0; bus4.br_valid = 1'b0;

    // Accept a branch, then reset next cycle with a flag write and a branch pending.
    exp_q.push_back(1'b1);
    drive(1'b0, 3'b000, 3'b000, 1'b1, 3'b111, a);
    check("accept_before_reset", 32'(a), 32'h1);
    rst = 1'b1;
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = 3'b000;
    bus.ex_flags  = 3'b111;
    bus.br_valid  = 1'b1;
    bus.br_ccc    = 3'b111;
    #1;
    check("ready_during_reset", 32'(bus.br_ready), 32'(FWD));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    check("post_reset_flags", 32'(flags_q), 32'h0);
    check("post_reset_stall", 32'(stall_cnt), 32'h0);
    check("post_reset_res_valid", 32'(bus.br_res_valid), 32'h0);
    check("post_reset_taken", 32'(bus.br_taken), 32'h0);
    check("post_reset_stall4", 32'(stall_cnt4), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
